// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and condition-code constants.
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NZP_W  = 3;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [NZP_W-1:0]  lc3b_nzp;

  localparam lc3b_nzp CC_NEG   = 3'b100;
  localparam lc3b_nzp CC_ZERO  = 3'b010;
  localparam lc3b_nzp CC_POS   = 3'b001;
  localparam lc3b_nzp CC_RESET = CC_ZERO;

endpackage

// File: rtl/gencc.sv
// Combinational nzp generator: exactly one bit set for any 16-bit result.
module gencc
  import lc3b_types::*;
(
  input  lc3b_word data,
  output lc3b_nzp  nzp_c
);

  // Sign bit wins, then the zero test, otherwise positive.
  always_comb begin
    nzp_c = CC_POS;
    if (data[WORD_W-1]) begin
      nzp_c = CC_NEG;
    end else if (data == '0) begin
      nzp_c = CC_ZERO;
    end
  end

endmodule

// File: rtl/cc_tracker.sv
// Condition-code tracker beside WB: architectural CC register plus a count of
// in-flight CC setters, so decode can stall a BR until the CC is final.
// Optional feature macro: CC_BYPASS_EN (same-cycle WB bypass into cc_out/cc_valid).
module cc_tracker
  import lc3b_types::*;
#(
  parameter  int unsigned MAX_PEND = 4,
  localparam int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic             issue_sets_cc,
  output logic             issue_ready,
  input  logic [CNT_W-1:0] flush_dec,
  input  logic             wb_valid,
  input  logic             wb_sets_cc,
  input  lc3b_word         wb_data,
  output lc3b_nzp          cc_out,
  output logic             cc_valid,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             proto_err
);

  localparam int unsigned SUM_W = CNT_W + 1;

  lc3b_nzp          cc_q;
  lc3b_nzp          wb_nzp;
  logic             inc;
  logic             dec;
  logic [SUM_W-1:0] add_sum;
  logic [SUM_W-1:0] sub_sum;
  logic             underflow;
  logic [CNT_W-1:0] pend_nxt;

  gencc u_gencc (
    .data  (wb_data),
    .nzp_c (wb_nzp)
  );

  // Ready depends on the held count only, so a full counter refuses an issue
  // even when a WB retires in the same cycle.
  assign issue_ready = (pend_cnt != CNT_W'(MAX_PEND));
  assign inc         = issue_valid & issue_sets_cc & issue_ready;
  assign dec         = wb_valid & wb_sets_cc;

  // Net the counter update; any negative result clamps to zero and flags misuse.
  always_comb begin
    add_sum   = {1'b0, pend_cnt} + SUM_W'(inc);
    sub_sum   = {1'b0, flush_dec} + SUM_W'(dec);
    underflow = (sub_sum > add_sum);
    pend_nxt  = '0;
    if (!underflow) begin
      pend_nxt = CNT_W'(add_sum - sub_sum);
    end
  end

  // Pending counter, sticky error and architectural CC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_cnt  <= '0;
      proto_err <= 1'b0;
      cc_q      <= CC_RESET;
    end else begin
      pend_cnt <= pend_nxt;
      if (underflow) begin
        proto_err <= 1'b1;
      end
      if (dec) begin
        cc_q <= wb_nzp;
      end
    end
  end

`ifdef CC_BYPASS_EN
  // Forward the retiring result so a branch behind the last setter need not wait.
  always_comb begin
    cc_out   = dec ? wb_nzp : cc_q;
    cc_valid = (pend_cnt == '0) | ((pend_cnt == CNT_W'(1)) & dec);
  end
`else
  // Publish the registered CC only once nothing is in flight.
  always_comb begin
    cc_out   = cc_q;
    cc_valid = (pend_cnt == '0);
  end
`endif

endmodule
